vx_tcu_tfr_align: RTL and testbench

//  Exponent-alignment stage of the TCU TFR FEDP pipeline, directly downstream of the mul/join stage.

---
 rtl/vx_tcu_pkg.sv | 25 ++
 rtl/vx_tcu_tfr_align_if.sv | 40 ++++
 rtl/vx_tcu_tfr_align.sv | 121 ++++++++++++
 tb/tb_vx_tcu_tfr_align.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vx_tcu_pkg.sv
// Shared TCU types: format IDs and the reduced exception bundle
// passed alongside FEDP data.
package vx_tcu_pkg;

    localparam logic [3:0] TCU_FP32_ID = 4'd0;
    localparam logic [3:0] TCU_FP16_ID = 4'd1;
    localparam logic [3:0] TCU_BF16_ID = 4'd2;
    localparam logic [3:0] TCU_I32_ID  = 4'd8;
    localparam logic [3:0] TCU_I8_ID   = 4'd9;
    localparam logic [3:0] TCU_U8_ID   = 4'd10;
    localparam logic [3:0] TCU_I4_ID   = 4'd11;
    localparam logic [3:0] TCU_U4_ID   = 4'd12;

    typedef struct packed {
        logic is_nan;
        logic is_inf;
        logic sign;
    } fedp_excep_t;

    function automatic logic tcu_fmt_is_int(logic [3:0] fmt);
        return fmt inside {TCU_I32_ID, TCU_I8_ID, TCU_U8_ID,
                           TCU_I4_ID, TCU_U4_ID};
    endfunction

endpackage

// File: rtl/vx_tcu_tfr_align_if.sv
// Valid/ready bundle between the mul/join stage, the alignment
// stage and the adder tree.
interface vx_tcu_tfr_align_if
    import vx_tcu_pkg::*;
#(
    parameter int N     = 2,
    parameter int TCK   = 2 * N,
    parameter int WA    = 28,
    parameter int EXP_W = 10
);
    logic                     valid_in;
    logic                     ready_in;
    logic [31:0]              req_id_in;
    logic [3:0]               fmt_s;
    logic [(TCK+1)*25-1:0]    sig_in;
    logic [(TCK+1)*EXP_W-1:0] exp_in;
    fedp_excep_t              exc_in;

    logic                     valid_out;
    logic                     ready_out;
    logic [31:0]              req_id_out;
    logic                     is_int_out;
    logic [(TCK+1)*WA-1:0]    sig_out;
    logic [EXP_W-1:0]         exp_max_out;
    fedp_excep_t              exc_out;

    modport master (
        output valid_in, req_id_in, fmt_s, sig_in, exp_in, exc_in,
        output ready_out,
        input  ready_in, valid_out, req_id_out, is_int_out,
        input  sig_out, exp_max_out, exc_out
    );

    modport slave (
        input  valid_in, req_id_in, fmt_s, sig_in, exp_in, exc_in,
        input  ready_out,
        output ready_in, valid_out, req_id_out, is_int_out,
        output sig_out, exp_max_out, exc_out
    );
endinterface

// File: rtl/vx_tcu_tfr_align.sv
// TFR FEDP exponent alignment: max-exponent search, then shift of
// every addend into a common two's-complement frame with sticky.
module vx_tcu_tfr_align
    import vx_tcu_pkg::*;
#(
    parameter int N     = 2,
    parameter int TCK   = 2 * N,
    parameter int WA    = 28,
    parameter int EXP_W = 10
) (
    input logic clk,
    input logic reset,
    vx_tcu_tfr_align_if.slave bus
);
    localparam int NL  = TCK + 1;
    localparam int LVL = $clog2(NL);
    localparam int P   = 1 << LVL;

    logic en;

    logic                  valid_s1;
    logic [31:0]           req_id_s1;
    logic                  is_int_s1;
    fedp_excep_t           exc_s1;
    logic [NL*25-1:0]      sig_s1;
    logic [NL*EXP_W-1:0]   exp_s1;
    logic [EXP_W-1:0]      emax_s1;

    logic [EXP_W-1:0]      tree [P];
    logic [EXP_W-1:0]      emax_c;
    logic [NL*WA-1:0]      sig_c;

    logic [24:0]           s;
    logic [EXP_W-1:0]      e;
    logic [EXP_W-1:0]      sh;
    logic [WA-1:0]         m;
    logic [WA-1:0]         r;
    logic [WA-1:0]         lost;
    logic [WA-1:0]         v;

    // Single global enable: a stalled output freezes both stages.
    assign en = ~bus.valid_out | bus.ready_out;
    assign bus.ready_in = en;

    // Pairwise reduction, padded with zero exponents to a power of two.
    always_comb begin
        for (int i = 0; i < P; i++) tree[i] = '0;
        for (int i = 0; i < NL; i++) tree[i] = bus.exp_in[i*EXP_W +: EXP_W];
        for (int w = P / 2; w > 0; w = w / 2) begin
            for (int i = 0; i < w; i++) begin
                tree[i] = (tree[2*i] > tree[2*i+1]) ? tree[2*i] : tree[2*i+1];
            end
        end
        emax_c = tree[0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_s1  <= 1'b0;
            req_id_s1 <= '0;
            is_int_s1 <= 1'b0;
            exc_s1    <= '0;
            sig_s1    <= '0;
            exp_s1    <= '0;
            emax_s1   <= '0;
        end else if (en) begin
            valid_s1  <= bus.valid_in;
            req_id_s1 <= bus.req_id_in;
            is_int_s1 <= tcu_fmt_is_int(bus.fmt_s);
            exc_s1    <= bus.exc_in;
            sig_s1    <= bus.sig_in;
            exp_s1    <= bus.exp_in;
            emax_s1   <= emax_c;
        end
    end

    // Shift-out mask also covers shamt >= WA: everything lands in sticky.
    always_comb begin
        sig_c = '0;
        s     = '0;
        e     = '0;
        sh    = '0;
        m     = '0;
        r     = '0;
        lost  = '0;
        v     = '0;
        for (int i = 0; i < NL; i++) begin
            s  = sig_s1[i*25 +: 25];
            e  = exp_s1[i*EXP_W +: EXP_W];
            sh = emax_s1 - e;
            m  = '0;
            m[WA-2 -: 24] = s[23:0];
            r    = m >> sh;
            lost = m & ~({WA{1'b1}} << sh);
            r[0] = r[0] | (|lost);
            v    = s[24] ? (~r + 1'b1) : r;
            if (e == '0) v = '0;
            if (is_int_s1) v = {{(WA-25){s[24]}}, s};
            sig_c[i*WA +: WA] = v;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.valid_out   <= 1'b0;
            bus.req_id_out  <= '0;
            bus.is_int_out  <= 1'b0;
            bus.exc_out     <= '0;
            bus.sig_out     <= '0;
            bus.exp_max_out <= '0;
        end else if (en) begin
            bus.valid_out   <= valid_s1;
            bus.req_id_out  <= req_id_s1;
            bus.is_int_out  <= is_int_s1;
            bus.exc_out     <= exc_s1;
            bus.sig_out     <= sig_c;
            bus.exp_max_out <= is_int_s1 ? '0 : emax_s1;
        end
    end

endmodule

// File: tb/tb_vx_tcu_tfr_align.sv
// Directed vectors, backpressure sequence and a randomised
// scoreboard run for the TFR alignment stage.
module tb_vx_tcu_tfr_align;
    import vx_tcu_pkg::*;

    localparam int NL = 5;
    localparam int WA = 28;
    localparam int EW = 10;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vx_tcu_tfr_align_if #(.N(2), .TCK(4), .WA(WA), .EXP_W(EW)) bus ();

    vx_tcu_tfr_align #(.N(2), .TCK(4), .WA(WA), .EXP_W(EW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [3:0]     fmt;
        logic [124:0]   sig;
        logic [49:0]    exp;
        logic [2:0]     exc;
        logic [139:0]   xsig;
        logic [9:0]     xmax;
    } vec_t;

    typedef struct packed {
        logic [31:0]  id;
        logic         isint;
        logic [139:0] sig;
        logic [9:0]   mx;
        logic [2:0]   exc;
    } beat_t;

    int    checks = 0;
    int    errors = 0;
    vec_t  vt [6];
    beat_t q [$];
    beat_t snap;
    logic  held = 1'b0;
    logic  bp_check = 1'b0;
    logic  accepted;
    int    popped;

    task automatic chk(string name, logic [255:0] act, logic [255:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    function automatic logic is_int_fmt(logic [3:0] f);
        return (f >= 4'd8) && (f <= 4'd12);
    endfunction

    function automatic logic [27:0] ref_lane(logic in_int, logic [24:0] s,
                                             logic [9:0] e, logic [9:0] mx);
        logic [63:0] full;
        logic [63:0] r;
        int sh;
        if (in_int) return {{3{s[24]}}, s};
        if (e == 10'd0) return 28'd0;
        full = {37'd0, s[23:0], 3'b000};
        sh = int'(mx) - int'(e);
        if (sh >= 28) begin
            r = (s[23:0] != 24'd0) ? 64'd1 : 64'd0;
        end else begin
            r = full >> sh;
            if ((r << sh) != full) r[0] = 1'b1;
        end
        return s[24] ? 28'(64'd0 - r) : r[27:0];
    endfunction

    function automatic beat_t model(logic [31:0] id, logic [3:0] fmt,
                                    logic [124:0] sig, logic [49:0] ex,
                                    logic [2:0] exc);
        beat_t b;
        logic [9:0] mx;
        mx = 10'd0;
        for (int i = 0; i < NL; i++)
            if (ex[i*EW +: EW] > mx) mx = ex[i*EW +: EW];
        b.id    = id;
        b.isint = is_int_fmt(fmt);
        b.exc   = exc;
        b.mx    = b.isint ? 10'd0 : mx;
        for (int i = 0; i < NL; i++)
            b.sig[i*WA +: WA] = ref_lane(b.isint, sig[i*25 +: 25],
                                         ex[i*EW +: EW], mx);
        return b;
    endfunction

    function automatic beat_t cur_out();
        beat_t b;
        b.id    = bus.req_id_out;
        b.isint = bus.is_int_out;
        b.sig   = bus.sig_out;
        b.mx    = bus.exp_max_out;
        b.exc   = bus.exc_out;
        return b;
    endfunction

    // Inputs are already driven just after a negedge; settle, then log.
    task automatic step();
        beat_t want;
        #1;
        accepted = bus.valid_in && bus.ready_in;
        if (bp_check && bus.valid_out && !bus.ready_out)
            chk("ready_in_stall", 256'(bus.ready_in), 256'(0));
        if (held) chk("hold_stable", 256'(cur_out()), 256'(snap));
        if (accepted)
            q.push_back(model(bus.req_id_in, bus.fmt_s, bus.sig_in,
                              bus.exp_in, bus.exc_in));
        if (bus.valid_out && bus.ready_out) begin
            if (q.size() == 0) begin
                chk("spurious_out", 256'(1), 256'(0));
            end else begin
                want = q.pop_front();
                popped++;
                chk("beat", 256'(cur_out()), 256'(want));
            end
        end
        held = bus.valid_out && !bus.ready_out;
        snap = cur_out();
        @(negedge clk);
    endtask

    task automatic rand_inputs();
        logic [3:0] fl [5];
        fl = '{4'd0, 4'd1, 4'd2, 4'd8, 4'd9};
        bus.fmt_s     = fl[$urandom_range(0, 4)];
        bus.req_id_in = $urandom;
        bus.exc_in    = 3'($urandom);
        for (int i = 0; i < NL; i++) begin
            bus.sig_in[i*25 +: 25] = 25'($urandom);
            bus.exp_in[i*EW +: EW] = ($urandom_range(0, 5) == 0) ? 10'd0
                                   : 10'(100 + $urandom_range(0, 40));
        end
    endtask

    initial begin
        vt[0] = '{4'd1,
            {25'h0800000, 25'h0800000, 25'h0800000, 25'h0800000, 25'h0800000},
            {10'd129, 10'd127, 10'd0, 10'd128, 10'd130}, 3'b000,
            {28'h2000000, 28'h0800000, 28'h0, 28'h1000000, 28'h4000000},
            10'd130};
        vt[1] = '{4'd0,
            {25'h1800000, 25'h1FFFFFF, 25'h0800001, 25'h1800001, 25'h0800000},
            {10'd129, 10'd0, 10'd126, 10'd100, 10'd130}, 3'b100,
            {28'hE000000, 28'h0, 28'h0400001, 28'hFFFFFFF, 28'h4000000},
            10'd130};
        vt[2] = '{TCU_I8_ID,
            {25'h0000000, 25'h0FFFFFF, 25'h1000000, 25'h0000005, 25'h1FFFFFF},
            {10'd200, 10'd0, 10'd3, 10'd77, 10'd1}, 3'b011,
            {28'h0, 28'h0FFFFFF, 28'hF000000, 28'h0000005, 28'hFFFFFFF},
            10'd0};
        vt[3] = '{4'd2,
            {25'h0000000, 25'h1FFFFFF, 25'h0000001, 25'h0800000, 25'h0FFFFFF},
            {10'd150, 10'd149, 10'd122, 10'd124, 10'd150}, 3'b010,
            {28'h0, 28'hC000004, 28'h1, 28'h1, 28'h7FFFFF8},
            10'd150};
        vt[4] = '{4'd0,
            {25'h1ABCDEF, 25'h1ABCDEF, 25'h1ABCDEF, 25'h1ABCDEF, 25'h1ABCDEF},
            {10'd0, 10'd0, 10'd0, 10'd0, 10'd0}, 3'b001,
            140'd0, 10'd0};
        vt[5] = '{4'd1,
            {25'h0FFFFFF, 25'h1000001, 25'h0000000, 25'h0000000, 25'h0000000},
            {10'd1023, 10'd1, 10'd0, 10'd0, 10'd0}, 3'b000,
            {28'h7FFFFF8, 28'hFFFFFFF, 28'h0, 28'h0, 28'h0},
            10'd1023};

        reset         = 1'b1;
        bus.ready_out = 1'b1;
        rand_inputs();
        bus.valid_in  = 1'b1;

        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_valid_out", 256'(bus.valid_out), 256'(0));
            chk("rst_sig_out", 256'(bus.sig_out), 256'(0));
        end
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_valid", 256'(bus.valid_out), 256'(0));
        chk("post_rst_sig", 256'(bus.sig_out), 256'(0));
        bus.valid_in = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 6; k++) begin
            bus.fmt_s     = vt[k].fmt;
            bus.sig_in    = vt[k].sig;
            bus.exp_in    = vt[k].exp;
            bus.exc_in    = vt[k].exc;
            bus.req_id_in = 32'(100 + k);
            bus.valid_in  = 1'b1;
            @(negedge clk);
            bus.valid_in = 1'b0;
            chk($sformatf("v%0d_latency", k), 256'(bus.valid_out), 256'(0));
            @(negedge clk);
            chk($sformatf("v%0d_valid", k), 256'(bus.valid_out), 256'(1));
            chk($sformatf("v%0d_sig", k), 256'(bus.sig_out), 256'(vt[k].xsig));
            chk($sformatf("v%0d_emax", k), 256'(bus.exp_max_out),
                256'(vt[k].xmax));
            chk($sformatf("v%0d_exc", k), 256'(bus.exc_out), 256'(vt[k].exc));
            chk($sformatf("v%0d_id", k), 256'(bus.req_id_out), 256'(100 + k));
            chk($sformatf("v%0d_isint", k), 256'(bus.is_int_out),
                256'(is_int_fmt(vt[k].fmt)));
        end
        @(negedge clk);

        begin
            int sent;
            sent = 0;
            popped = 0;
            bp_check = 1'b1;
            for (int c = 0; c < 16; c++) begin
                rand_inputs();
                bus.req_id_in = 32'(200 + sent);
                bus.valid_in  = (sent < 6);
                bus.ready_out = !(c inside {3, 4, 5});
                step();
                if (accepted) sent++;
            end
            bp_check = 1'b0;
            chk("bp_sent", 256'(sent), 256'(6));
            chk("bp_emerged", 256'(popped), 256'(6));
            chk("bp_queue_empty", 256'(q.size()), 256'(0));
        end

        for (int c = 0; c < 10000; c++) begin
            rand_inputs();
            bus.valid_in  = ($urandom_range(0, 3) != 0);
            bus.ready_out = ($urandom_range(0, 3) != 0);
            step();
        end
        bus.valid_in  = 1'b0;
        bus.ready_out = 1'b1;
        for (int c = 0; c < 5; c++) step();
        chk("rand_drained", 256'(q.size()), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
